// File: rtl/icache_direct_if.sv
// rtl/icache_direct_if.sv - core fetch and fetcher fill/snoop signal bundle for icache_direct
`timescale 1ns/1ps
interface icache_direct_if #(
  parameter int ADDR_WIDTH = 64
);
  // core side
  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic                  stall;
  logic                  resp_valid;
  logic [31:0]           resp_instr;
  logic [ADDR_WIDTH-1:0] resp_pc;
  // fetcher side
  logic                  out_miss;
  logic [ADDR_WIDTH-1:0] out_miss_pc;
  logic [9:0]            fill_offset;
  logic [511:0]          fill_data;
  logic                  inv_valid;
  logic [ADDR_WIDTH-1:0] inv_phys_addr;

  modport master (
    output req_valid, req_pc, fill_offset, fill_data, inv_valid, inv_phys_addr,
    input  stall, resp_valid, resp_instr, resp_pc, out_miss, out_miss_pc
  );

  modport slave (
    input  req_valid, req_pc, fill_offset, fill_data, inv_valid, inv_phys_addr,
    output stall, resp_valid, resp_instr, resp_pc, out_miss, out_miss_pc
  );
endinterface

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped L1 instruction cache with miss/fill and snoop invalidation
`timescale 1ns/1ps
module icache_direct #(
  parameter int NUM_SETS   = 64,
  parameter int ADDR_WIDTH = 64
) (
  input logic             clk,
  input logic             reset,
  icache_direct_if.slave  bus
);

  localparam int INDEX_BITS = $clog2(NUM_SETS);
  localparam int TAG_BITS   = ADDR_WIDTH - 6 - INDEX_BITS;

  typedef enum logic [1:0] {
    LOOKUP  = 2'd0,
    MISS    = 2'd1,
    DELIVER = 2'd2
  } state_t;

  // line storage; data and tags carry no reset, only valid bits do
  logic [511:0]          data_q  [NUM_SETS];
  logic [TAG_BITS-1:0]   tag_q   [NUM_SETS];
  logic [NUM_SETS-1:0]   valid_q;

  state_t                state;
  logic                  poison;
  logic [ADDR_WIDTH-1:0] pend_pc;
  logic                  stall_q;
  logic                  resp_valid_q;
  logic [31:0]           resp_instr_q;
  logic [ADDR_WIDTH-1:0] resp_pc_q;
  logic                  out_miss_q;
  logic [ADDR_WIDTH-1:0] out_miss_pc_q;

  // address fields of the request, the pending miss and the snoop
  logic [3:0]            req_word;
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [3:0]            pend_word;
  logic [INDEX_BITS-1:0] pend_idx;
  logic [TAG_BITS-1:0]   pend_tag;
  logic [INDEX_BITS-1:0] inv_idx;
  logic [TAG_BITS-1:0]   inv_tag;

  assign req_word  = bus.req_pc[5:2];
  assign req_idx   = bus.req_pc[6 +: INDEX_BITS];
  assign req_tag   = bus.req_pc[ADDR_WIDTH-1 -: TAG_BITS];
  assign pend_word = pend_pc[5:2];
  assign pend_idx  = pend_pc[6 +: INDEX_BITS];
  assign pend_tag  = pend_pc[ADDR_WIDTH-1 -: TAG_BITS];
  assign inv_idx   = bus.inv_phys_addr[6 +: INDEX_BITS];
  assign inv_tag   = bus.inv_phys_addr[ADDR_WIDTH-1 -: TAG_BITS];

  // word offset and low snoop bits carry no cache state
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.req_pc[1:0], bus.inv_phys_addr[5:0]};

  logic [511:0] req_line;
  logic [511:0] pend_line;
  logic [31:0]  req_instr;
  logic [31:0]  pend_instr;

  assign req_line   = data_q[req_idx];
  assign pend_line  = data_q[pend_idx];
  assign req_instr  = req_line[{req_word, 5'd0} +: 32];
  assign pend_instr = pend_line[{pend_word, 5'd0} +: 32];

  logic inv_hit;
  logic inv_pend;
  logic accept;
  logic lookup_hit;
  logic fill_done;

  // snoop that finds a live copy of its line
  assign inv_hit    = bus.inv_valid && valid_q[inv_idx] && (tag_q[inv_idx] == inv_tag);
  // snoop naming the line currently being fetched (tracked even though it is not yet valid)
  assign inv_pend   = bus.inv_valid && (inv_idx == pend_idx) && (inv_tag == pend_tag);
  assign accept     = (state == LOOKUP) && bus.req_valid;
  // a same-cycle snoop of the looked-up line turns the hit into a miss
  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag)
                      && !(inv_hit && (inv_idx == req_idx));
  assign fill_done  = (state == MISS) && (bus.fill_offset == 10'd512);

  // install the completed line; a reset cycle never writes
  always_ff @(posedge clk) begin
    if (reset && fill_done) begin
      data_q[pend_idx] <= bus.fill_data;
      tag_q[pend_idx]  <= pend_tag;
    end
  end

  // lookup/miss/deliver sequencing, valid bits and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= LOOKUP;
      valid_q       <= '0;
      poison        <= 1'b0;
      pend_pc       <= '0;
      stall_q       <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_instr_q  <= '0;
      resp_pc_q     <= '0;
      out_miss_q    <= 1'b0;
      out_miss_pc_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      if (inv_hit) begin
        valid_q[inv_idx] <= 1'b0;
      end
      case (state)
        LOOKUP: begin
          if (accept) begin
            if (lookup_hit) begin
              resp_valid_q <= 1'b1;
              resp_instr_q <= req_instr;
              resp_pc_q    <= bus.req_pc;
            end else begin
              pend_pc       <= bus.req_pc;
              out_miss_q    <= 1'b1;
              out_miss_pc_q <= {bus.req_pc[ADDR_WIDTH-1:6], 6'd0};
              stall_q       <= 1'b1;
              poison        <= 1'b0;
              state         <= MISS;
            end
          end
        end
        MISS: begin
          if (fill_done) begin
            // a snoop on this very edge counts the same as an earlier one
            valid_q[pend_idx] <= ~(poison | inv_pend);
            out_miss_q        <= 1'b0;
            state             <= DELIVER;
          end else if (inv_pend) begin
            poison <= 1'b1;
          end
        end
        DELIVER: begin
          resp_valid_q <= 1'b1;
          resp_instr_q <= pend_instr;
          resp_pc_q    <= pend_pc;
          stall_q      <= 1'b0;
          state        <= LOOKUP;
        end
        default: begin
          state <= LOOKUP;
        end
      endcase
    end
  end

  assign bus.stall       = stall_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_instr  = resp_instr_q;
  assign bus.resp_pc     = resp_pc_q;
  assign bus.out_miss    = out_miss_q;
  assign bus.out_miss_pc = out_miss_pc_q;

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - scoreboard bench for icache_direct
`timescale 1ns/1ps
module tb_icache_direct;

  localparam int AW = 64;

  logic clk = 1'b0;
  logic reset;

  icache_direct_if #(.ADDR_WIDTH(AW)) bus ();

  icache_direct #(.NUM_SETS(64), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  logic [511:0] line_a, line_b, line_c, line_d;

  function automatic logic [511:0] make_line(input logic [31:0] seed);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = seed + 32'(k) * 32'h0101_0101;
    return l;
  endfunction

  function automatic logic [31:0] word_of(input logic [511:0] l, input int k);
    return l[32*k +: 32];
  endfunction

  // advance one clock and score any response against the queue
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.resp_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got pc=%h instr=%h, expected no response", bus.resp_pc, bus.resp_instr);
      end else begin
        e = sb.pop_front();
        if (bus.resp_pc !== e.pc || bus.resp_instr !== e.instr) begin
          errors++;
          $display("FAIL resp_data: got pc=%h instr=%h, expected pc=%h instr=%h", bus.resp_pc, bus.resp_instr, e.pc, e.instr);
        end
      end
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d responses outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic send_req(input logic [63:0] pc);
    bus.req_valid = 1'b1;
    bus.req_pc    = pc;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic send_fill(input logic [511:0] line);
    bus.fill_data   = line;
    bus.fill_offset = 10'd512;
    step();
    bus.fill_offset = 10'd0;
    step();
  endtask

  task automatic test_reset();
    checks++;
    if (bus.stall !== 1'b0 || bus.resp_valid !== 1'b0 || bus.out_miss !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: stall=%b resp_valid=%b out_miss=%b, expected 0 0 0", bus.stall, bus.resp_valid, bus.out_miss);
    end
    checks++;
    if (bus.resp_instr !== 32'd0 || bus.resp_pc !== 64'd0 || bus.out_miss_pc !== 64'd0) begin
      errors++;
      $display("FAIL reset_data: instr=%h pc=%h miss_pc=%h, expected zeros", bus.resp_instr, bus.resp_pc, bus.out_miss_pc);
    end
  endtask

  task automatic test_cold_miss();
    send_req(64'h1008);
    checks++;
    if (bus.out_miss !== 1'b1 || bus.out_miss_pc !== 64'h1000 || bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL cold_miss: out_miss=%b miss_pc=%h stall=%b, expected 1 1000 1", bus.out_miss, bus.out_miss_pc, bus.stall);
    end
    bus.fill_data   = line_a;
    bus.fill_offset = 10'd448;
    step();
    bus.fill_offset = 10'd0;
    checks++;
    if (bus.out_miss !== 1'b1 || bus.out_miss_pc !== 64'h1000) begin
      errors++;
      $display("FAIL partial_fill: out_miss=%b miss_pc=%h, expected 1 1000", bus.out_miss, bus.out_miss_pc);
    end
    sb.push_back('{64'h1008, 32'hDEADBEEF});
    bus.fill_offset = 10'd512;
    step();
    bus.fill_offset = 10'd0;
    checks++;
    if (bus.out_miss !== 1'b0 || bus.stall !== 1'b1 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL fill_edge: out_miss=%b stall=%b resp_valid=%b, expected 0 1 0", bus.out_miss, bus.stall, bus.resp_valid);
    end
    step();
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL deliver_stall: stall=%b, expected 0", bus.stall);
    end
    drain("cold_miss");
  endtask

  task automatic test_hit_stream();
    for (int i = 0; i < 16; i++) begin
      logic [63:0] pc;
      pc = 64'h1000 + 64'(4 * i);
      checks++;
      if (bus.stall !== 1'b0) begin
        errors++;
        $display("FAIL stream_stall_%0d: stall=%b, expected 0", i, bus.stall);
      end
      sb.push_back('{pc, word_of(line_a, i)});
      bus.req_valid = 1'b1;
      bus.req_pc    = pc;
      step();
      checks++;
      if (bus.resp_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream_latency_%0d: resp_valid=%b, expected 1", i, bus.resp_valid);
      end
    end
    bus.req_valid = 1'b0;
    drain("hit_stream");
  endtask

  task automatic test_conflict();
    sb.push_back('{64'h1000, word_of(line_a, 0)});
    send_req(64'h1000);
    checks++;
    if (bus.out_miss !== 1'b0) begin
      errors++;
      $display("FAIL conflict_hit: out_miss=%b, expected 0", bus.out_miss);
    end
    send_req(64'h2000);
    checks++;
    if (bus.out_miss !== 1'b1 || bus.out_miss_pc !== 64'h2000) begin
      errors++;
      $display("FAIL conflict_miss: out_miss=%b miss_pc=%h, expected 1 2000", bus.out_miss, bus.out_miss_pc);
    end
    sb.push_back('{64'h2000, word_of(line_b, 0)});
    send_fill(line_b);
    drain("conflict_fill");
    send_req(64'h1000);
    checks++;
    if (bus.out_miss !== 1'b1 || bus.out_miss_pc !== 64'h1000) begin
      errors++;
      $display("FAIL conflict_evict: out_miss=%b miss_pc=%h, expected 1 1000", bus.out_miss, bus.out_miss_pc);
    end
    sb.push_back('{64'h1000, word_of(line_a, 0)});
    send_fill(line_a);
    drain("conflict_refill");
  endtask

  task automatic test_invalidate();
    bus.inv_valid     = 1'b1;
    bus.inv_phys_addr = 64'h1020;
    step();
    bus.inv_valid = 1'b0;
    send_req(64'h1004);
    checks++;
    if (bus.out_miss !== 1'b1 || bus.out_miss_pc !== 64'h1000) begin
      errors++;
      $display("FAIL inv_miss: out_miss=%b miss_pc=%h, expected 1 1000", bus.out_miss, bus.out_miss_pc);
    end
    sb.push_back('{64'h1004, word_of(line_a, 1)});
    send_fill(line_a);
    drain("inv_refill");
    // snoop and hit on the same edge: the snoop wins
    bus.inv_valid     = 1'b1;
    bus.inv_phys_addr = 64'h1000;
    send_req(64'h1008);
    bus.inv_valid = 1'b0;
    checks++;
    if (bus.out_miss !== 1'b1 || bus.out_miss_pc !== 64'h1000) begin
      errors++;
      $display("FAIL inv_same_cycle: out_miss=%b miss_pc=%h, expected 1 1000", bus.out_miss, bus.out_miss_pc);
    end
    sb.push_back('{64'h1008, word_of(line_a, 2)});
    send_fill(line_a);
    drain("inv_same_cycle");
  endtask

  task automatic test_inv_during_fill();
    send_req(64'h3000);
    checks++;
    if (bus.out_miss !== 1'b1 || bus.out_miss_pc !== 64'h3000) begin
      errors++;
      $display("FAIL poison_miss: out_miss=%b miss_pc=%h, expected 1 3000", bus.out_miss, bus.out_miss_pc);
    end
    bus.inv_valid     = 1'b1;
    bus.inv_phys_addr = 64'h3000;
    step();
    bus.inv_valid = 1'b0;
    sb.push_back('{64'h3000, word_of(line_c, 0)});
    send_fill(line_c);
    drain("poison_deliver");
    send_req(64'h3000);
    checks++;
    if (bus.out_miss !== 1'b1) begin
      errors++;
      $display("FAIL poison_left_invalid: out_miss=%b, expected 1", bus.out_miss);
    end
    sb.push_back('{64'h3000, word_of(line_c, 0)});
    send_fill(line_c);
    drain("poison_refill");
    sb.push_back('{64'h3004, word_of(line_c, 1)});
    send_req(64'h3004);
    checks++;
    if (bus.out_miss !== 1'b0) begin
      errors++;
      $display("FAIL clean_fill_hit: out_miss=%b, expected 0", bus.out_miss);
    end
    // fill completion and snoop of the same line on one edge
    send_req(64'h2000);
    bus.inv_valid     = 1'b1;
    bus.inv_phys_addr = 64'h2000;
    sb.push_back('{64'h2000, word_of(line_b, 0)});
    bus.fill_data   = line_b;
    bus.fill_offset = 10'd512;
    step();
    bus.inv_valid   = 1'b0;
    bus.fill_offset = 10'd0;
    step();
    drain("fill_inv_edge");
    send_req(64'h2000);
    checks++;
    if (bus.out_miss !== 1'b1) begin
      errors++;
      $display("FAIL fill_inv_edge_invalid: out_miss=%b, expected 1", bus.out_miss);
    end
    sb.push_back('{64'h2000, word_of(line_b, 0)});
    send_fill(line_b);
    drain("fill_inv_refill");
  endtask

  task automatic test_reset_mid_fill();
    send_req(64'h5040);
    checks++;
    if (bus.out_miss !== 1'b1 || bus.out_miss_pc !== 64'h5040) begin
      errors++;
      $display("FAIL rst_fill_miss: out_miss=%b miss_pc=%h, expected 1 5040", bus.out_miss, bus.out_miss_pc);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.out_miss !== 1'b0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: out_miss=%b stall=%b, expected 0 0", bus.out_miss, bus.stall);
    end
    step();
    step();
    reset = 1'b1;
    send_req(64'h5040);
    checks++;
    if (bus.out_miss !== 1'b1 || bus.out_miss_pc !== 64'h5040) begin
      errors++;
      $display("FAIL rst_no_stale: out_miss=%b miss_pc=%h, expected 1 5040", bus.out_miss, bus.out_miss_pc);
    end
    sb.push_back('{64'h5040, word_of(line_d, 0)});
    send_fill(line_d);
    drain("rst_refill");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    line_a = make_line(32'hA000_0000);
    line_a[64 +: 32] = 32'hDEADBEEF;
    line_b = make_line(32'hB000_0000);
    line_c = make_line(32'hC000_0000);
    line_d = make_line(32'hD000_0000);
    reset             = 1'b0;
    bus.req_valid     = 1'b0;
    bus.req_pc        = '0;
    bus.fill_offset   = 10'd0;
    bus.fill_data     = '0;
    bus.inv_valid     = 1'b0;
    bus.inv_phys_addr = '0;
    step();
    step();
    test_reset();
    reset = 1'b1;
    step();
    test_cold_miss();
    test_hit_stream();
    test_conflict();
    test_invalidate();
    test_inv_during_fill();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
